// File: rtl/mem_access_ctrl_if.sv
// CPU-side and memory-side signal bundle for mem_access_ctrl.
// The slave modport is the controller's view; master is the environment (CPU + memories).
interface mem_access_ctrl_if;
    logic        REQ;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic [31:0] RDATA;
    logic        READY;
    logic        STALL;
    logic        ERR;
    logic        INT_CS;
    logic        INT_WE;
    logic [31:0] INT_ADDR;
    logic [31:0] INT_WDATA;
    logic [31:0] INT_RDATA;
    logic        EXT_REQ;
    logic        EXT_WE;
    logic [31:0] EXT_ADDR;
    logic [31:0] EXT_WDATA;
    logic        EXT_ACK;
    logic [31:0] EXT_RDATA;

    modport slave (
        input  REQ, WE, ADDR, WDATA, INT_RDATA, EXT_ACK, EXT_RDATA,
        output RDATA, READY, STALL, ERR, INT_CS, INT_WE, INT_ADDR, INT_WDATA,
               EXT_REQ, EXT_WE, EXT_ADDR, EXT_WDATA
    );

    modport master (
        output REQ, WE, ADDR, WDATA, INT_RDATA, EXT_ACK, EXT_RDATA,
        input  RDATA, READY, STALL, ERR, INT_CS, INT_WE, INT_ADDR, INT_WDATA,
               EXT_REQ, EXT_WE, EXT_ADDR, EXT_WDATA
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Routes single CPU accesses to an internal window [INF, SUP) or an external bus.
// Optional external-wait timeout with ERR reporting is built when MEMCTRL_TIMEOUT_EN is defined.
//
// state       | meaning
// ST_IDLE     | waiting for REQ; latches address/data/direction
// ST_INT      | internal memory selected for one cycle
// ST_EXT_WAIT | external request held until EXT_ACK (or timeout)
// ST_DONE     | READY pulse, then back to idle
module mem_access_ctrl #(
    parameter logic [31:0] INF         = 32'h4B00,
    parameter logic [31:0] SUP         = 32'h4F00,
    parameter int          EXT_TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    mem_access_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INT      = 2'd1,
        ST_EXT_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        int_cs_q, int_cs_d;
    logic        int_we_q, int_we_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic        in_window;

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int CW = $clog2(EXT_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic          unused_timeout;
    assign unused_timeout = ^EXT_TIMEOUT;
`endif

    assign in_window = (bus.ADDR >= INF) && (bus.ADDR < SUP);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        int_cs_d  = 1'b1;
        int_we_d  = 1'b0;
        ext_req_d = ext_req_q;
        ext_we_d  = ext_we_q;
`ifdef MEMCTRL_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ) begin
                    addr_d  = bus.ADDR;
                    wdata_d = bus.WDATA;
                    we_d    = bus.WE;
                    if (in_window) begin
                        state_d  = ST_INT;
                        int_cs_d = 1'b0;
                        int_we_d = bus.WE;
                    end else begin
                        state_d   = ST_EXT_WAIT;
                        ext_req_d = 1'b1;
                        ext_we_d  = bus.WE;
`ifdef MEMCTRL_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            ST_INT: begin
                if (!we_q) rdata_d = bus.INT_RDATA;
                state_d = ST_DONE;
                ready_d = 1'b1;
            end
            ST_EXT_WAIT: begin
                // an ACK in the final counted cycle still wins over the timeout
                if (bus.EXT_ACK) begin
                    if (!we_q) rdata_d = bus.EXT_RDATA;
                    state_d   = ST_DONE;
                    ready_d   = 1'b1;
                    ext_req_d = 1'b0;
                    ext_we_d  = 1'b0;
                end
`ifdef MEMCTRL_TIMEOUT_EN
                else if (cnt_q == CW'(EXT_TIMEOUT - 1)) begin
                    state_d   = ST_DONE;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    ext_req_d = 1'b0;
                    ext_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            int_cs_q  <= 1'b1;
            int_we_q  <= 1'b0;
            ext_req_q <= 1'b0;
            ext_we_q  <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            int_cs_q  <= int_cs_d;
            int_we_q  <= int_we_d;
            ext_req_q <= ext_req_d;
            ext_we_q  <= ext_we_d;
`ifdef MEMCTRL_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.RDATA     = rdata_q;
    assign bus.READY     = ready_q;
    assign bus.STALL     = bus.REQ & ~ready_q;
    assign bus.INT_CS    = int_cs_q;
    assign bus.INT_WE    = int_we_q;
    assign bus.INT_ADDR  = addr_q;
    assign bus.INT_WDATA = wdata_q;
    assign bus.EXT_REQ   = ext_req_q;
    assign bus.EXT_WE    = ext_we_q;
    assign bus.EXT_ADDR  = addr_q;
    assign bus.EXT_WDATA = wdata_q;
`ifdef MEMCTRL_TIMEOUT_EN
    assign bus.ERR       = err_q;
`else
    assign bus.ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected RDATA/ERR queued per request,
// compared on each READY; latency, routing, reset and window boundaries checked inline.
module tb_mem_access_ctrl;

    localparam logic [31:0] INF_TB = 32'h4B00;
    localparam logic [31:0] SUP_TB = 32'h4F00;
    localparam int          TMO_TB = 16;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .INF         (INF_TB),
        .SUP         (SUP_TB),
        .EXT_TIMEOUT (TMO_TB)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          int_cs_cnt = 0;
    int          ext_req_cnt = 0;
    exp_t        sb_q[$];
    logic [31:0] exp_rdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (!bus.INT_CS) int_cs_cnt++;
            if (bus.EXT_REQ) ext_req_cnt++;
            chk("stall", {31'd0, bus.STALL}, {31'd0, bus.REQ & ~bus.READY});
            if (bus.READY) begin
                if (sb_q.size() == 0) begin
                    chk("ready_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rdata", bus.RDATA, e.rdata);
                    chk("err", {31'd0, bus.ERR}, {31'd0, e.err});
                end
            end
        end
    end

    // Caller is positioned 1 time unit after a rising edge with the DUT idle.
    // ack_dly = EXT_WAIT cycle in which EXT_ACK is given (0 = never).
    task automatic do_access(input string name, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] data,
                             input int ack_dly, input int exp_lat, input logic exp_err,
                             input bit drop_req);
        bit   internal;
        bit   done;
        exp_t e;
        internal = (addr >= INF_TB) && (addr < SUP_TB);
        if (!we && !exp_err) exp_rdata = data;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        int_cs_cnt  = 0;
        ext_req_cnt = 0;
        bus.REQ   = 1'b1;
        bus.WE    = we;
        bus.ADDR  = addr;
        bus.WDATA = wdata;
        if (internal) begin
            bus.INT_RDATA = data;
            bus.EXT_ACK   = 1'b1;
            bus.EXT_RDATA = ~data;
        end
        done = 1'b0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (!internal) begin
                bus.EXT_ACK   = (cyc == ack_dly);
                bus.EXT_RDATA = (cyc == ack_dly) ? data : $urandom;
            end
            if (cyc == 1) begin
                if (internal) begin
                    chk({name, "_int_addr"}, bus.INT_ADDR, addr);
                    chk({name, "_int_we"}, {31'd0, bus.INT_WE}, {31'd0, we});
                    chk({name, "_int_wdata"}, bus.INT_WDATA, wdata);
                end else begin
                    chk({name, "_ext_addr"}, bus.EXT_ADDR, addr);
                    chk({name, "_ext_we"}, {31'd0, bus.EXT_WE}, {31'd0, we});
                    chk({name, "_ext_wdata"}, bus.EXT_WDATA, wdata);
                end
                if (drop_req) begin
                    bus.REQ   = 1'b0;
                    bus.ADDR  = $urandom;
                    bus.WDATA = $urandom;
                    bus.WE    = ~we;
                end
            end
            if (bus.READY) begin
                chk({name, "_latency"}, cyc, exp_lat);
                done = 1'b1;
            end
        end
        if (!done) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
        chk({name, "_int_cs_cycles"}, int_cs_cnt, internal ? 1 : 0);
        chk({name, "_ext_req_cycles"}, ext_req_cnt, internal ? 0 : exp_lat - 1);
        bus.REQ       = 1'b0;
        bus.EXT_ACK   = 1'b0;
        bus.INT_RDATA = $urandom;
        bus.EXT_RDATA = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_rdata"}, bus.RDATA, 32'd0);
        chk({name, "_ready"}, {31'd0, bus.READY}, 32'd0);
        chk({name, "_err"}, {31'd0, bus.ERR}, 32'd0);
        chk({name, "_int_cs"}, {31'd0, bus.INT_CS}, 32'd1);
        chk({name, "_int_we"}, {31'd0, bus.INT_WE}, 32'd0);
        chk({name, "_ext_req"}, {31'd0, bus.EXT_REQ}, 32'd0);
        chk({name, "_ext_we"}, {31'd0, bus.EXT_WE}, 32'd0);
        chk({name, "_ext_addr"}, bus.EXT_ADDR, 32'd0);
        chk({name, "_ext_wdata"}, bus.EXT_WDATA, 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.REQ       = 1'b0;
        bus.WE        = 1'b0;
        bus.ADDR      = '0;
        bus.WDATA     = '0;
        bus.INT_RDATA = 32'hDEAD_BEEF;
        bus.EXT_ACK   = 1'b0;
        bus.EXT_RDATA = 32'hFEED_F00D;
        #1;
        check_reset_outputs("por");
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_access("int_rd_inf",  1'b0, 32'h4B00, 32'h0, 32'h1234_5678, 0, 2, 1'b0, 1'b0);
        do_access("int_rd_top",  1'b0, 32'h4EFF, 32'h0, 32'hA5A5_0101, 0, 2, 1'b0, 1'b0);
        do_access("ext_rd_sup",  1'b0, 32'h4F00, 32'h0, 32'h0BAD_F00D, 3, 4, 1'b0, 1'b0);
        do_access("ext_wr_zero", 1'b1, 32'h0000, 32'hCAFE_0001, 32'h1111_2222, 5, 6, 1'b0, 1'b0);
        do_access("int_wr",      1'b1, 32'h4C00, 32'h7777_8888, 32'h3333_4444, 0, 2, 1'b0, 1'b0);
        do_access("ext_rd_below",1'b0, 32'h4AFF, 32'h0, 32'h5555_AAAA, 1, 2, 1'b0, 1'b0);
        do_access("ext_rd_drop", 1'b0, 32'h8000_0000, 32'h0, 32'h6666_9999, 4, 5, 1'b0, 1'b1);
        do_access("int_rd_drop", 1'b0, 32'h4D10, 32'h0, 32'h0F0F_F0F0, 0, 2, 1'b0, 1'b1);

        // reset in the third external wait cycle abandons the access
        bus.REQ   = 1'b1;
        bus.WE    = 1'b0;
        bus.ADDR  = 32'h0001_0000;
        bus.WDATA = 32'h0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_rst_pre_ext_req", {31'd0, bus.EXT_REQ}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        bus.REQ = 1'b0;
        #1;
        rst = 1'b0;
        exp_rdata = '0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(posedge clk);
            #1;
            chk("mid_rst_no_ready", {31'd0, bus.READY}, 32'd0);
        end
        do_access("post_rst_int", 1'b0, 32'h4B40, 32'h0, 32'h2468_ACE0, 0, 2, 1'b0, 1'b0);
        do_access("post_rst_ext", 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h1357_9BDF, 2, 3, 1'b0, 1'b0);

`ifdef MEMCTRL_TIMEOUT_EN
        do_access("ext_timeout", 1'b0, 32'h0000_1000, 32'h0, 32'h9999_9999, 0, TMO_TB + 1, 1'b1, 1'b0);
        bus.EXT_ACK   = 1'b1;
        bus.EXT_RDATA = 32'hBBBB_CCCC;
        @(posedge clk);
        #1;
        bus.EXT_ACK = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk);
            #1;
            chk("late_ack_no_ready", {31'd0, bus.READY}, 32'd0);
        end
        chk("late_ack_rdata", bus.RDATA, exp_rdata);
`endif

        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk);
            #1;
        end
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
